pfu_predict: RTL

Registered fetch-PC unit with a direct-mapped branch target buffer (BTB). It is the next generation of the combinational PFU next-PC logic: it owns the F-stage PC register and predicts taken branches and jumps one cycle early while keeping MIPS delay-slot semantics. Branches resolve in D; a mismatch redirects fetch with no flush, because the delay slot is always valid. Exceptions and ERET override everything.

---
 rtl/pfu_predict.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pfu_predict.sv
// Registered fetch-PC unit with a direct-mapped BTB. It predicts taken control flow one cycle
// early, keeps the MIPS delay slot, and redirects from D on a misprediction.
module pfu_predict #(
   parameter logic [31:0] RESET_PC      = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR    = 32'h0000_4180,
   parameter int          BTB_ENTRIES   = 8,
   parameter bit          PRED_EN       = 1'b1,
   parameter int          PFU_OP_LENGTH = 3
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     stall_i,
   input  logic                     exc_valid_i,
   input  logic                     eret_valid_i,
   input  logic [31:0]              epc_i,
   input  logic                     res_valid_i,
   input  logic [31:0]              res_pc_i,
   input  logic [PFU_OP_LENGTH-1:0] res_op_i,
   input  logic [15:0]              res_imm16_i,
   input  logic [25:0]              res_imm26_i,
   input  logic [31:0]              res_rs_i,
   input  logic                     res_pred_taken_i,
   input  logic [31:0]              res_pred_target_i,
   output logic [31:0]              pc_f_o,
   output logic                     pred_taken_f_o,
   output logic [31:0]              pred_target_f_o,
   output logic [31:0]              res_link_o,
   output logic                     mispredict_o
);

   localparam int IDX  = $clog2(BTB_ENTRIES);
   localparam int TAGW = 30 - IDX;

   localparam logic [PFU_OP_LENGTH-1:0] PFU_OP_NEXT      = PFU_OP_LENGTH'(0);
   localparam logic [PFU_OP_LENGTH-1:0] PFU_OP_JUMP      = PFU_OP_LENGTH'(1);
   localparam logic [PFU_OP_LENGTH-1:0] PFU_OP_OFFSET_16 = PFU_OP_LENGTH'(2);
   localparam logic [PFU_OP_LENGTH-1:0] PFU_OP_OFFSET_26 = PFU_OP_LENGTH'(3);
   localparam logic [PFU_OP_LENGTH-1:0] PFU_OP_RS        = PFU_OP_LENGTH'(4);

   logic [31:0]            pc_q, pc_d;
   logic                   pendValid_q, pendValid_d;
   logic [31:0]            pendTarget_q, pendTarget_d;

   logic [BTB_ENTRIES-1:0] btbValid_q;
   logic [TAGW-1:0]        btbTag_q    [BTB_ENTRIES];
   logic [31:0]            btbTarget_q [BTB_ENTRIES];

   logic [IDX-1:0]         lkIdx;
   logic [TAGW-1:0]        lkTag;
   logic                   lkHit;
   logic [IDX-1:0]         wrIdx;
   logic [TAGW-1:0]        wrTag;
   logic [31:0]            seqPc;
   logic [31:0]            actTarget;
   logic                   actTaken;

   assign lkIdx = pc_q[IDX+1:2];
   assign lkTag = pc_q[31:IDX+2];
   assign wrIdx = res_pc_i[IDX+1:2];
   assign wrTag = res_pc_i[31:IDX+2];

   // A pending target means this fetch is a delay slot, so its own BTB hit must be ignored.
   assign lkHit = PRED_EN && btbValid_q[lkIdx] && (btbTag_q[lkIdx] == lkTag) && !pendValid_q;

   assign pc_f_o          = pc_q;
   assign pred_taken_f_o  = lkHit;
   assign pred_target_f_o = lkHit ? btbTarget_q[lkIdx] : 32'h0;

   assign seqPc      = res_pc_i + 32'd4;
   assign res_link_o = res_pc_i + 32'd8;

   always_comb begin
      actTaken  = 1'b0;
      actTarget = res_link_o;
      case (res_op_i)
         PFU_OP_JUMP: begin
            actTaken  = 1'b1;
            actTarget = {res_pc_i[31:28], res_imm26_i, 2'b00};
         end
         PFU_OP_OFFSET_16: begin
            actTaken  = 1'b1;
            actTarget = seqPc + {{14{res_imm16_i[15]}}, res_imm16_i, 2'b00};
         end
         PFU_OP_OFFSET_26: begin
            actTaken  = 1'b1;
            actTarget = seqPc + {{4{res_imm26_i[25]}}, res_imm26_i, 2'b00};
         end
         PFU_OP_RS: begin
            actTaken  = 1'b1;
            actTarget = res_rs_i;
         end
         default: ;
      endcase
   end

   assign mispredict_o = res_valid_i &
                         ((actTaken != res_pred_taken_i) |
                          (actTaken & (actTarget != res_pred_target_i)));

   // BTB valid bits: taken resolutions allocate, not-taken ones invalidate only a matching entry.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         btbValid_q <= '0;
      end else if (res_valid_i) begin
         if (actTaken) begin
            btbValid_q[wrIdx] <= 1'b1;
         end else if (btbValid_q[wrIdx] && (btbTag_q[wrIdx] == wrTag)) begin
            btbValid_q[wrIdx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (res_valid_i && actTaken) begin
         btbTag_q[wrIdx]    <= wrTag;
         btbTarget_q[wrIdx] <= actTarget;
      end
   end

   always_comb begin
      pc_d         = pc_q;
      pendValid_d  = pendValid_q;
      pendTarget_d = pendTarget_q;
      if (exc_valid_i) begin
         pc_d        = EXC_VECTOR;
         pendValid_d = 1'b0;
      end else if (eret_valid_i) begin
         pc_d        = epc_i;
         pendValid_d = 1'b0;
      end else if (mispredict_o) begin
         pc_d        = actTarget;
         pendValid_d = 1'b0;
      end else if (stall_i) begin
         pc_d        = pc_q;
      end else if (pendValid_q) begin
         pc_d        = pendTarget_q;
         pendValid_d = 1'b0;
      end else begin
         pc_d = pc_q + 32'd4;
         if (lkHit) begin
            pendValid_d  = 1'b1;
            pendTarget_d = btbTarget_q[lkIdx];
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pc_q         <= RESET_PC;
         pendValid_q  <= 1'b0;
         pendTarget_q <= 32'h0;
      end else begin
         pc_q         <= pc_d;
         pendValid_q  <= pendValid_d;
         pendTarget_q <= pendTarget_d;
      end
   end

endmodule
